// File: rtl/fpga_cfg_loader.sv
// Configuration-chain loader: turns a byte stream into NUM_CHAINS serial chain loads
// driven by an internally generated prog_clk, with an optional read-back verify pass.
module fpga_cfg_loader #(
   parameter int NUM_CHAINS = 1,
   parameter int CHAIN_LEN  = 256,
   parameter int DIV        = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 verify,
   input  logic                                 abort,
   input  logic [7:0]                           in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic                                 prog_clk,
   output logic [NUM_CHAINS-1:0]                ccff_head,
   input  logic [NUM_CHAINS-1:0]                ccff_tail,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 error,
   output logic [NUM_CHAINS-1:0]                err_mask,
   output logic [$clog2(CHAIN_LEN+1)-1:0]       step_cnt
);

   localparam int STEP_W         = $clog2(CHAIN_LEN + 1);
   localparam int DIV_W          = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int STEPS_PER_BYTE = 8 / NUM_CHAINS;
   localparam int SLOT_W         = $clog2(STEPS_PER_BYTE + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(CHAIN_LEN - 1);
   localparam logic [SLOT_W-1:0] SLOTS_INIT = SLOT_W'(STEPS_PER_BYTE - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      PASS_END = 3'd4
   } state_t;

   state_t                state;
   logic [7:0]            shift_buf;
   logic [SLOT_W-1:0]     slots_left;
   logic [DIV_W-1:0]      div_cnt;
   logic                  pass;
   logic                  verify_q;
   logic [NUM_CHAINS-1:0] mismatch;

   // In pass 2 the tail still shows the bit loaded at the same step of pass 1.
   assign mismatch = ccff_tail ^ ccff_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         prog_clk   <= 1'b0;
         ccff_head  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_mask   <= '0;
         step_cnt   <= '0;
         shift_buf  <= '0;
         slots_left <= '0;
         div_cnt    <= '0;
         pass       <= 1'b0;
         verify_q   <= 1'b0;
      end else if (abort) begin
         // Chain contents and verify results are deliberately left untouched.
         state    <= IDLE;
         in_ready <= 1'b0;
         prog_clk <= 1'b0;
         busy     <= 1'b0;
         div_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  verify_q <= verify;
                  error    <= 1'b0;
                  err_mask <= '0;
                  done     <= 1'b0;
                  step_cnt <= '0;
                  pass     <= 1'b0;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
               end
            end

            FETCH: begin
               if (in_valid && in_ready) begin
                  ccff_head  <= in_data[NUM_CHAINS-1:0];
                  shift_buf  <= in_data >> NUM_CHAINS;
                  slots_left <= SLOTS_INIT;
                  in_ready   <= 1'b0;
                  div_cnt    <= '0;
                  state      <= SHIFT_LO;
               end
            end

            SHIFT_LO: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  prog_clk <= 1'b1;
                  state    <= SHIFT_HI;
                  if (pass) begin
                     err_mask <= err_mask | mismatch;
                     if (|mismatch) error <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            SHIFT_HI: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  prog_clk <= 1'b0;
                  step_cnt <= step_cnt + STEP_W'(1);
                  if (step_cnt == STEP_LAST) begin
                     state <= PASS_END;
                  end else if (slots_left != '0) begin
                     ccff_head  <= shift_buf[NUM_CHAINS-1:0];
                     shift_buf  <= shift_buf >> NUM_CHAINS;
                     slots_left <= slots_left - SLOT_W'(1);
                     state      <= SHIFT_LO;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= FETCH;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            PASS_END: begin
               if (verify_q && !pass) begin
                  pass     <= 1'b1;
                  step_cnt <= '0;
                  in_ready <= 1'b1;
                  state    <= FETCH;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
